hazard_detect: RTL and testbench

//  Hazard detection for the ID/EX boundary, directly upstream of the stall-control block.
//  It drives that block's LoadUseHazard input, which freezes PC, IF/ID and ID/EX and bubbles EX/MEM.
//  Two hazard sources are detected:
//   - Load-use: combinational.
//   - Multi-cycle DIV/REM (M extension): an FSM holds the divide in EX for DIV_CYCLES cycles.

---
 rtl/hazard_detect.sv | 90 +++++++++
 tb/tb_hazard_detect.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect.sv
// Load-use and multi-cycle divide hazard detection at the ID/EX boundary.
// Drives the stall request and keeps free-running stall statistics.
module hazard_detect #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ID_rs1,
   input  logic [REG_AW-1:0] ID_rs2,
   input  logic              ID_use_rs1,
   input  logic              ID_use_rs2,
   input  logic [REG_AW-1:0] IDEX_rd,
   input  logic              IDEX_MemRead,
   input  logic              IDEX_is_div,
   input  logic              kill,
   output logic              LoadUseHazard,
   output logic              div_busy,
   output logic              div_done,
   output logic [CNT_W-1:0]  lu_stall_cnt,
   output logic [CNT_W-1:0]  div_stall_cnt
);

   localparam int unsigned CW = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [CNT_W-1:0] lu_cnt, div_cnt;
   logic            lu, div_stall, done_raw;

   assign lu = IDEX_MemRead && (IDEX_rd != '0) &&
               ((ID_use_rs1 && (ID_rs1 == IDEX_rd)) ||
                (ID_use_rs2 && (ID_rs2 == IDEX_rd)));

   // Divide FSM next state; kill overrides everything and returns to IDLE
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      div_stall = 1'b0;
      done_raw  = 1'b0;
      case (state)
         IDLE: begin
            div_stall = IDEX_is_div && !kill;
            if (div_stall) begin
               cnt_nx   = CW'(DIV_CYCLES - 2);
               state_nx = (DIV_CYCLES == 2) ? DONE : RUN;
            end
         end
         RUN: begin
            div_stall = 1'b1;
            cnt_nx    = cnt - CW'(1);
            if (cnt == CW'(1)) state_nx = DONE;
         end
         DONE: begin
            done_raw = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (kill) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         lu_cnt  <= '0;
         div_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (lu && !kill)        lu_cnt  <= lu_cnt + CNT_W'(1);
         if (div_stall && !kill) div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Outputs are held at zero for as long as reset is asserted
   assign LoadUseHazard = rst_n && (lu || div_stall) && !kill;
   assign div_busy      = rst_n && (state != IDLE);
   assign div_done      = rst_n && done_raw && !kill;
   assign lu_stall_cnt  = rst_n ? lu_cnt  : '0;
   assign div_stall_cnt = rst_n ? div_cnt : '0;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: one 4-cycle divider instance (32-bit counters)
// and one 2-cycle divider instance with 3-bit counters for wrap checking.
module tb_hazard_detect;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, idex_rd;
   logic       use_rs1, use_rs2, mem_read, is_div, kill;

   logic        a_luh, a_busy, a_done;
   logic [31:0] a_lu_cnt, a_div_cnt;
   logic        b_luh, b_busy, b_done;
   logic [2:0]  b_lu_cnt, b_div_cnt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   hazard_detect #(.REG_AW(5), .DIV_CYCLES(4), .CNT_W(32)) u_a (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_use_rs1(use_rs1), .ID_use_rs2(use_rs2),
      .IDEX_rd(idex_rd), .IDEX_MemRead(mem_read), .IDEX_is_div(is_div), .kill(kill),
      .LoadUseHazard(a_luh), .div_busy(a_busy), .div_done(a_done),
      .lu_stall_cnt(a_lu_cnt), .div_stall_cnt(a_div_cnt)
   );

   hazard_detect #(.REG_AW(5), .DIV_CYCLES(2), .CNT_W(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_use_rs1(use_rs1), .ID_use_rs2(use_rs2),
      .IDEX_rd(idex_rd), .IDEX_MemRead(mem_read), .IDEX_is_div(is_div), .kill(kill),
      .LoadUseHazard(b_luh), .div_busy(b_busy), .div_done(b_done),
      .lu_stall_cnt(b_lu_cnt), .div_stall_cnt(b_div_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one cycle; inputs are then changed and outputs sampled mid-cycle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; mem_read = 1'b0; is_div = 1'b0; kill = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tick();
      // reset state, with a hazard pattern present while reset is held
      mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
      #1;
      check("rst_luh", a_luh, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_lucnt", a_lu_cnt, 0);
      check("rst_divcnt", a_div_cnt, 0);
      do_reset();

      // 1: load x5 then add x6,x5,x7
      mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1; id_rs2 = 5'd7; use_rs2 = 1'b1;
      #1;
      check("lu_hit", a_luh, 1);
      check("lu_cnt0", a_lu_cnt, 0);
      tick();
      mem_read = 1'b0;
      #1;
      check("lu_bubble", a_luh, 0);
      check("lu_cnt1", a_lu_cnt, 1);

      // 2: load x0 never hazards; unused rs1 never hazards
      mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; use_rs1 = 1'b1; id_rs2 = 5'd0; use_rs2 = 1'b1;
      #1;
      check("lu_x0", a_luh, 0);
      tick();
      check("lu_x0_cnt", a_lu_cnt, 1);
      idex_rd = 5'd3; id_rs1 = 5'd3; use_rs1 = 1'b0; id_rs2 = 5'd9; use_rs2 = 1'b1;
      #1;
      check("lu_nouse", a_luh, 0);
      id_rs2 = 5'd3;
      #1;
      check("lu_rs2", a_luh, 1);
      tick();
      idle_inputs();
      #1;
      check("lu_cnt2", a_lu_cnt, 2);

      // 3: 4-cycle divide
      do_reset();
      is_div = 1'b1;
      #1;
      check("div4_T_luh", a_luh, 1);
      check("div4_T_busy", a_busy, 0);
      tick();
      check("div4_T1_luh", a_luh, 1);
      check("div4_T1_busy", a_busy, 1);
      check("div4_T1_done", a_done, 0);
      tick();
      check("div4_T2_luh", a_luh, 1);
      check("div4_T2_done", a_done, 0);
      tick();
      check("div4_T3_luh", a_luh, 0);
      check("div4_T3_done", a_done, 1);
      tick();
      is_div = 1'b0;
      #1;
      check("div4_T4_done", a_done, 0);
      check("div4_T4_busy", a_busy, 0);
      check("div4_cnt", a_div_cnt, 3);

      // 4: 2-cycle divide, back to back
      do_reset();
      is_div = 1'b1;
      #1;
      check("div2_T_luh", b_luh, 1);
      tick();
      check("div2_T1_luh", b_luh, 0);
      check("div2_T1_done", b_done, 1);
      tick();
      check("div2_T2_luh", b_luh, 1);
      check("div2_T2_done", b_done, 0);
      check("div2_T2_busy", b_busy, 0);
      tick();
      check("div2_T3_done", b_done, 1);
      tick();
      is_div = 1'b0;
      #1;
      check("div2_T4_luh", b_luh, 0);
      check("div2_T4_busy", b_busy, 0);
      check("div2_cnt", b_div_cnt, 2);

      // 5: kill at T+1 of a 4-cycle divide
      do_reset();
      is_div = 1'b1;
      #1;
      check("kill_T_luh", a_luh, 1);
      tick();
      kill = 1'b1;
      #1;
      check("kill_T1_luh", a_luh, 0);
      check("kill_T1_done", a_done, 0);
      tick();
      kill = 1'b0; is_div = 1'b0;
      #1;
      check("kill_T2_busy", a_busy, 0);
      check("kill_T2_done", a_done, 0);
      tick();
      check("kill_T3_done", a_done, 0);
      check("kill_cnt", a_div_cnt, 1);

      // 6: reset mid-divide
      do_reset();
      is_div = 1'b1;
      tick();
      check("rrun_busy", a_busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; is_div = 1'b0;
      #1;
      check("rrun_busy_after", a_busy, 0);
      check("rrun_divcnt", a_div_cnt, 0);
      check("rrun_lucnt", a_lu_cnt, 0);

      // 3-bit counter wraps after eight load-use stall cycles
      do_reset();
      mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("wrap_cnt", b_lu_cnt, 32'(i));
         tick();
      end
      check("wrap_zero", b_lu_cnt, 0);
      check("wrap_wide", a_lu_cnt, 8);

      idle_inputs();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
